// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the 8 requesters and the round-robin arbiter.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       s2;
  logic       s1;
  logic       s0;
  logic       valid;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, s2, s1, s0, valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, s2, s1, s0, valid, timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for one shared 8:1 selector. The owner keeps the bus until
// it finishes, drops its request, or reaches the hold limit.
//
//   state | meaning
//   IDLE  | no owner, gnt=0, scanning requests from ptr
//   BUSY  | owner sel holds the bus, hold_cnt counts its cycles
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter8_if.slave   bus
);
  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [7:0]    gnt, gnt_nxt;
  logic [2:0]    sel, sel_nxt;
  logic [2:0]    ptr, ptr_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          timeout, timeout_nxt;

  logic [2:0]    start;
  logic [2:0]    idx;
  logic [2:0]    win;
  logic          found;
  logic          at_limit;
  logic          release_now;

  // Scan downward so the requester closest to start is the last (winning) write.
  always_comb begin
    start = (state == BUSY) ? sel + 3'd1 : ptr;
    found = 1'b0;
    win   = start;
    idx   = start;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign at_limit    = (hold_cnt == HW'(MAX_HOLD - 1));
  assign release_now = bus.done | ~bus.req[sel] | at_limit;

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    sel_nxt     = sel;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
          gnt_nxt   = 8'b1 << win;
          sel_nxt   = win;
          hold_nxt  = '0;
        end
      end
      BUSY: begin
        if (!release_now) begin
          hold_nxt = hold_cnt + HW'(1);
        end else begin
          ptr_nxt     = sel + 3'd1;
          timeout_nxt = at_limit & ~bus.done & bus.req[sel];
          hold_nxt    = '0;
          if (found) begin
            gnt_nxt = 8'b1 << win;
            sel_nxt = win;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      timeout  <= timeout_nxt;
    end
  end

  assign bus.gnt     = gnt;
  assign bus.s2      = sel[2];
  assign bus.s1      = sel[1];
  assign bus.s0      = sel[0];
  assign bus.valid   = |gnt;
  assign bus.timeout = timeout;
endmodule
